// File: rtl/uart_tx_fifo_engine_if.sv
// uart_tx_fifo_engine_if: producer-side enqueue handshake for the UART transmit engine
interface uart_tx_fifo_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 transfer_req;
    logic                 transfer_ready;
    modport master (output data_in, transfer_req, input transfer_ready);
    modport slave  (input data_in, transfer_req, output transfer_ready);
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// uart_tx_fifo_engine: queued UART transmitter with configurable width, baud, parity and stop bits
module uart_tx_fifo_engine #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    uart_tx_fifo_engine_if.slave        bus,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 ready, push, pop, tick, last_stop;
    assign ready              = fifo_level != (AW+1)'(FIFO_DEPTH);
    assign bus.transfer_ready = ready;
    assign push               = bus.transfer_req && ready;
    assign tick               = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_stop          = state == S_STOP && tick && bit_idx == IW'(STOP_BITS - 1);
    assign pop                = fifo_level != '0 && (state == S_IDLE || last_stop);
    // Queue pointers and occupancy; push and pop together leave the level unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) fifo_level <= push ? fifo_level + 1'b1 : fifo_level - 1'b1;
        end
    end
    // Word storage needs no reset: clearing the pointers empties the queue
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end
    // Frame sequencer: pop starts a frame on the same edge, bits advance on baud terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            cnt <= (tick || state == S_IDLE) ? '0 : cnt + 1'b1;
            if (pop) begin
                state   <= S_START;
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
                bit_idx <= '0;
                uart_tx <= 1'b0;
                busy    <= 1'b1;
            end else if (tick) begin
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        uart_tx <= shreg[0];
                    end
                    S_DATA: begin
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            uart_tx <= (PARITY != 0) ? par_bit : 1'b1;
                            bit_idx <= '0;
                        end else begin
                            shreg   <= shreg >> 1;
                            uart_tx <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        state   <= S_STOP;
                        uart_tx <= 1'b1;
                    end
                    S_STOP: begin
                        if (last_stop) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// tb_uart_tx_fifo_engine: five engine configurations checked against a frame-level line model
module tb_uart_tx_fifo_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int db  [5] = '{8, 8, 8, 7, 9};
    int cpb [5] = '{4, 4, 4, 1, 4};
    int par [5] = '{0, 1, 2, 0, 0};
    int sb  [5] = '{1, 1, 1, 2, 1};

    int n_cmp = 0;
    int n_bad = 0;
    int nbusy;
    logic [15:0] cap;
    logic exp_q[$];

    uart_tx_fifo_engine_if #(.DATA_BITS(8)) b0();
    uart_tx_fifo_engine_if #(.DATA_BITS(8)) b1();
    uart_tx_fifo_engine_if #(.DATA_BITS(8)) b2();
    uart_tx_fifo_engine_if #(.DATA_BITS(7)) b3();
    uart_tx_fifo_engine_if #(.DATA_BITS(9)) b4();

    logic tx0, tx1, tx2, tx3, tx4, bz0, bz1, bz2, bz3, bz4;
    logic [2:0] lv0, lv1, lv2, lv3, lv4;
    logic [4:0] tx, bz, rdy;
    logic [2:0] lv [5];
    assign tx  = {tx4, tx3, tx2, tx1, tx0};
    assign bz  = {bz4, bz3, bz2, bz1, bz0};
    assign rdy = {b4.transfer_ready, b3.transfer_ready, b2.transfer_ready, b1.transfer_ready, b0.transfer_ready};
    assign lv[0] = lv0;
    assign lv[1] = lv1;
    assign lv[2] = lv2;
    assign lv[3] = lv3;
    assign lv[4] = lv4;

    uart_tx_fifo_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave), .uart_tx(tx0), .busy(bz0), .fifo_level(lv0));
    uart_tx_fifo_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave), .uart_tx(tx1), .busy(bz1), .fifo_level(lv1));
    uart_tx_fifo_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave), .uart_tx(tx2), .busy(bz2), .fifo_level(lv2));
    uart_tx_fifo_engine #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset_n(reset_n), .bus(b3.slave), .uart_tx(tx3), .busy(bz3), .fifo_level(lv3));
    uart_tx_fifo_engine #(.DATA_BITS(9), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .bus(b4.slave), .uart_tx(tx4), .busy(bz4), .fifo_level(lv4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic r, input logic [8:0] w);
        case (k)
            0: begin b0.transfer_req = r; b0.data_in = w[7:0]; end
            1: begin b1.transfer_req = r; b1.data_in = w[7:0]; end
            2: begin b2.transfer_req = r; b2.data_in = w[7:0]; end
            3: begin b3.transfer_req = r; b3.data_in = w[6:0]; end
            default: begin b4.transfer_req = r; b4.data_in = w; end
        endcase
    endtask

    // Line level of frame bit i: start, data LSB first, optional parity, stop bits
    function automatic logic bit_at(input int k, input logic [8:0] w, input int i);
        logic p;
        p = 1'b0;
        for (int j = 0; j < db[k]; j++) p ^= w[j];
        if (i == 0) return 1'b0;
        if (i <= db[k]) return w[i-1];
        if (par[k] != 0 && i == db[k] + 1) return (par[k] == 1) ? p : ~p;
        return 1'b1;
    endfunction

    function automatic int flen(input int k);
        return 1 + db[k] + ((par[k] != 0) ? 1 : 0) + sb[k];
    endfunction

    task automatic add_frame(input int k, input logic [8:0] w);
        for (int i = 0; i < flen(k); i++)
            repeat (cpb[k]) exp_q.push_back(bit_at(k, w, i));
    endtask

    task automatic check_stream(input int k, input int idle, input string nm);
        int idx;
        logic e;
        idx = 0;
        nbusy = 0;
        cap = '1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            if (idx % cpb[k] == 0 && idx / cpb[k] < 16) cap[idx / cpb[k]] = tx[k];
            if (bz[k] === 1'b1) nbusy++;
            n_cmp++;
            if (tx[k] !== e) begin
                n_bad++;
                $display("FAIL %s tx cycle %0d: got %b want %b", nm, idx, tx[k], e);
            end
            n_cmp++;
            if (bz[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy cycle %0d: got %b want 1", nm, idx, bz[k]);
            end
            idx++;
        end
        repeat (idle) begin
            step();
            if (bz[k] === 1'b1) nbusy++;
            n_cmp++;
            if ({tx[k], bz[k], lv[k]} !== 5'b10000) begin
                n_bad++;
                $display("FAIL %s idle: got tx=%b busy=%b level=%0d want tx=1 busy=0 level=0", nm, tx[k], bz[k], lv[k]);
            end
        end
    endtask

    task automatic test_single(input int k, input logic [8:0] w, input string nm);
        drive(k, 1'b1, w);
        step();
        drive(k, 1'b0, 9'h0);
        n_cmp++;
        if ({tx[k], bz[k], lv[k]} !== 5'b10001) begin
            n_bad++;
            $display("FAIL %s push_edge: got tx=%b busy=%b level=%0d want tx=1 busy=0 level=1", nm, tx[k], bz[k], lv[k]);
        end
        exp_q.delete();
        add_frame(k, w);
        check_stream(k, 3, nm);
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({tx[k], bz[k], rdy[k], lv[k]} !== 6'b101000) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got tx=%b busy=%b ready=%b level=%0d want 1 0 1 0", k, tx[k], bz[k], rdy[k], lv[k]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_cmp++;
        if ({tx[0], bz[0], rdy[0], lv[0]} !== 6'b101000) begin
            n_bad++;
            $display("FAIL after_reset: got tx=%b busy=%b ready=%b level=%0d want 1 0 1 0", tx[0], bz[0], rdy[0], lv[0]);
        end
    endtask

    task automatic test_basic();
        test_single(0, 9'h0A5, "a5");
        n_cmp++;
        if (cap[9:0] !== 10'b1101001010) begin
            n_bad++;
            $display("FAIL a5_bits: got %b want 1101001010", cap[9:0]);
        end
        n_cmp++;
        if (nbusy !== 40) begin
            n_bad++;
            $display("FAIL a5_busy_len: got %0d want 40", nbusy);
        end
    endtask

    task automatic test_parity();
        test_single(1, 9'h007, "even");
        n_cmp++;
        if (cap[9] !== 1'b1 || nbusy !== 44) begin
            n_bad++;
            $display("FAIL even_parity: got bit=%b busy=%0d want bit=1 busy=44", cap[9], nbusy);
        end
        test_single(2, 9'h007, "odd");
        n_cmp++;
        if (cap[9] !== 1'b0 || nbusy !== 44) begin
            n_bad++;
            $display("FAIL odd_parity: got bit=%b busy=%0d want bit=0 busy=44", cap[9], nbusy);
        end
    endtask

    task automatic test_short_frame();
        test_single(3, 9'h055, "d7s2");
        n_cmp++;
        if (cap[9:0] !== 10'b1110101010 || nbusy !== 10) begin
            n_bad++;
            $display("FAIL d7s2_frame: got bits=%b busy=%0d want bits=1110101010 busy=10", cap[9:0], nbusy);
        end
    endtask

    task automatic test_wide();
        test_single(4, 9'h1FF, "d9");
        n_cmp++;
        if (cap[10:0] !== 11'b11111111110 || nbusy !== 44) begin
            n_bad++;
            $display("FAIL d9_frame: got bits=%b busy=%0d want bits=11111111110 busy=44", cap[10:0], nbusy);
        end
    endtask

    task automatic test_back_to_back();
        int lexp [6] = '{1, 1, 2, 3, 4, 4};
        logic e;
        exp_q.delete();
        for (int i = 1; i <= 5; i++) add_frame(0, 9'(i));
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 9'(i + 1));
            step();
            n_cmp++;
            if (lv[0] !== 3'(lexp[i]) || rdy[0] !== (lexp[i] != 4)) begin
                n_bad++;
                $display("FAIL b2b_level edge %0d: got level=%0d ready=%b want level=%0d ready=%b", i + 1, lv[0], rdy[0], lexp[i], lexp[i] != 4);
            end
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (tx[0] !== e) begin
                    n_bad++;
                    $display("FAIL b2b_tx edge %0d: got %b want %b", i + 1, tx[0], e);
                end
            end
        end
        drive(0, 1'b0, 9'h0);
        check_stream(0, 50, "b2b");
    endtask

    task automatic test_reset_mid();
        logic [8:0] w [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = 9'($urandom_range(0, 255));
            drive(0, 1'b1, w[i]);
            step();
        end
        drive(0, 1'b0, 9'h0);
        repeat (17) step();
        n_cmp++;
        if (tx[0] !== bit_at(0, w[0], 4) || bz[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_bit3: got tx=%b busy=%b want tx=%b busy=1", tx[0], bz[0], bit_at(0, w[0], 4));
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx[0], bz[0], rdy[0], lv[0]} !== 6'b101000) begin
            n_bad++;
            $display("FAIL mid_reset: got tx=%b busy=%b ready=%b level=%0d want 1 0 1 0", tx[0], bz[0], rdy[0], lv[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) begin
            step();
            n_cmp++;
            if ({tx[0], bz[0], rdy[0], lv[0]} !== 6'b101000) begin
                n_bad++;
                $display("FAIL post_reset_idle: got tx=%b busy=%b ready=%b level=%0d want 1 0 1 0", tx[0], bz[0], rdy[0], lv[0]);
            end
        end
    endtask

    task automatic test_random(input int k, input int ncyc);
        int pt[$];
        int st[$];
        logic [8:0] wq[$];
        int len, last_end, lvl, s;
        logic etx, ebz, erdy, req;
        logic [8:0] w;
        len = flen(k) * cpb[k];
        last_end = 0;
        for (int t = 1; t <= ncyc + 5 * len + 10; t++) begin
            lvl = 0;
            foreach (pt[j]) if (pt[j] <= t - 1 && st[j] > t - 1) lvl++;
            erdy = (lvl != 4);
            n_cmp++;
            if (rdy[k] !== erdy) begin
                n_bad++;
                $display("FAIL rand%0d ready t=%0d: got %b want %b", k, t, rdy[k], erdy);
            end
            req = (t <= ncyc) && ($urandom_range(0, 3) == 0);
            w = 9'($urandom);
            drive(k, req, w);
            if (req && erdy) begin
                s = (t + 1 > last_end) ? t + 1 : last_end;
                pt.push_back(t);
                st.push_back(s);
                wq.push_back(w);
                last_end = s + len;
            end
            step();
            etx = 1'b1;
            ebz = 1'b0;
            lvl = 0;
            foreach (st[j]) begin
                if (st[j] <= t && t < st[j] + len) begin
                    etx = bit_at(k, wq[j], (t - st[j]) / cpb[k]);
                    ebz = 1'b1;
                end
                if (pt[j] <= t && st[j] > t) lvl++;
            end
            n_cmp++;
            if ({tx[k], bz[k], lv[k]} !== {etx, ebz, 3'(lvl)}) begin
                n_bad++;
                $display("FAIL rand%0d line t=%0d: got tx=%b busy=%b level=%0d want tx=%b busy=%b level=%0d", k, t, tx[k], bz[k], lv[k], etx, ebz, lvl);
            end
        end
        drive(k, 1'b0, 9'h0);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) drive(k, 1'b0, 9'h0);
        test_reset();
        test_basic();
        test_parity();
        test_short_frame();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 800);
        test_random(3, 400);
        test_random(1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
